// File: rtl/umi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// umi_pkg : UMI opcodes, packet field layout and response-packet builder
// Rev 1.0
// ---------------------------------------------------------------------------
package umi_pkg;

  localparam logic [7:0] UMI_WRITE     = 8'h01;
  localparam logic [7:0] UMI_READ      = 8'h02;
  localparam logic [7:0] UMI_READ_RESP = 8'h03;

  localparam int unsigned UMI_PKT_W      = 256;
  localparam int unsigned UMI_OPCODE_LSB = 0;
  localparam int unsigned UMI_OPCODE_W   = 8;
  localparam int unsigned UMI_DST_LSB    = 32;
  localparam int unsigned UMI_SRC_LSB    = 96;
  localparam int unsigned UMI_ADDR_W     = 64;
  localparam int unsigned UMI_DATA_LSB   = 160;
  localparam int unsigned UMI_DATA_W     = 32;

  typedef struct packed {
    logic [63:0] rsvd_hi;
    logic [31:0] data;
    logic [63:0] srcaddr;
    logic [63:0] dstaddr;
    logic [23:0] rsvd_lo;
    logic [7:0]  opcode;
  } umi_pkt_t;

  function automatic umi_pkt_t umi_make_resp(input logic [63:0] dst,
                                             input logic [63:0] src,
                                             input logic [31:0] data);
    umi_pkt_t p;
    p         = '0;
    p.opcode  = UMI_READ_RESP;
    p.dstaddr = dst;
    p.srcaddr = src;
    p.data    = data;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/umi_mem_sram.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// umi_mem_sram : single-port synchronous RAM, write-first, 1-cycle read
// Rev 1.0
// ---------------------------------------------------------------------------
module umi_mem_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/umi_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// umi_mem_responder : UMI WRITE/READ responder backed by a local word memory
// Rev 1.0
// ---------------------------------------------------------------------------
module umi_mem_responder
  import umi_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [63:0] BASE     = 64'h0,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UMI_PKT_W-1:0] umi_packet_rx,
  input  logic                 umi_valid_rx,
  output logic                 umi_ready_rx,
  output logic [UMI_PKT_W-1:0] umi_packet_tx,
  output logic                 umi_valid_tx,
  input  logic                 umi_ready_tx,
  output logic [15:0]          err_count
);

  localparam int unsigned C_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] C_SPAN = 64'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ready_rx;
  logic        r_valid_tx;
  umi_pkt_t    r_pkt_tx;
  logic [15:0] r_err_count;
  logic [63:0] r_req_dst;
  logic [63:0] r_req_src;
  logic        r_req_oor;

  logic [7:0]      w_opcode;
  logic [63:0]     w_dst;
  logic [63:0]     w_src;
  logic [31:0]     w_data;
  logic [63:0]     w_off;
  logic            w_in_range;
  logic [C_AW-1:0] w_idx;
  logic            w_is_wr;
  logic            w_is_rd;
  logic            w_rx_fire;
  logic            w_tx_fire;
  logic            w_ram_en;
  logic            w_ram_we;
  logic            w_err_evt;
  logic [31:0]     w_ram_rdata;
  logic            w_unused_rsvd;

  assign w_opcode = umi_packet_rx[UMI_OPCODE_LSB +: UMI_OPCODE_W];
  assign w_dst    = umi_packet_rx[UMI_DST_LSB +: UMI_ADDR_W];
  assign w_src    = umi_packet_rx[UMI_SRC_LSB +: UMI_ADDR_W];
  assign w_data   = umi_packet_rx[UMI_DATA_LSB +: UMI_DATA_W];
  assign w_unused_rsvd = ^{umi_packet_rx[UMI_PKT_W-1:UMI_DATA_LSB+UMI_DATA_W],
                           umi_packet_rx[UMI_DST_LSB-1:UMI_OPCODE_W]};

  // Range test on the offset so a window near the top of the space cannot overflow.
  assign w_off      = w_dst - BASE;
  assign w_in_range = (w_dst >= BASE) && (w_off < C_SPAN);
  assign w_idx      = w_off[C_AW+1:2];

  assign w_is_wr   = (w_opcode == UMI_WRITE);
  assign w_is_rd   = (w_opcode == UMI_READ);
  assign w_rx_fire = (r_state == S_IDLE) && r_ready_rx && umi_valid_rx && !rst;
  assign w_tx_fire = (r_state == S_RESP) && r_valid_tx && umi_ready_tx;
  assign w_ram_we  = w_rx_fire && w_is_wr && w_in_range;
  assign w_ram_en  = w_rx_fire && (w_is_wr || w_is_rd) && w_in_range;
  assign w_err_evt = w_rx_fire && (!(w_is_wr || w_is_rd) || !w_in_range);

  umi_mem_sram #(
    .DEPTH (DEPTH),
    .AW    (C_AW)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (w_data),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready_rx  <= 1'b0;
      r_valid_tx  <= 1'b0;
      r_pkt_tx    <= '0;
      r_err_count <= 16'd0;
      r_req_dst   <= 64'd0;
      r_req_src   <= 64'd0;
      r_req_oor   <= 1'b0;
    end else begin
      if (w_err_evt && (r_err_count != 16'hFFFF))
        r_err_count <= r_err_count + 16'd1;

      case (r_state)
        S_IDLE: begin
          r_ready_rx <= 1'b1;
          if (w_rx_fire && w_is_rd) begin
            r_ready_rx <= 1'b0;
            r_req_dst  <= w_dst;
            r_req_src  <= w_src;
            r_req_oor  <= !w_in_range;
            r_state    <= S_RD;
          end
        end
        S_RD: begin
          r_pkt_tx <= umi_make_resp(r_req_src, r_req_dst,
                                    r_req_oor ? ERR_DATA : w_ram_rdata);
          r_state  <= S_RESP;
        end
        S_RESP: begin
          // valid rises one cycle after entering RESP and holds until taken
          if (w_tx_fire) begin
            r_valid_tx <= 1'b0;
            r_ready_rx <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_valid_tx <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign umi_ready_rx  = r_ready_rx;
  assign umi_valid_tx  = r_valid_tx;
  assign umi_packet_tx = r_pkt_tx;
  assign err_count     = r_err_count;

endmodule
`default_nettype wire
